// File: rtl/store_rr_scheduler.sv
// Store-only BRAM write-port scheduler: round-robin arbitration across store ports,
// registered write stage, and a pending-store counter gating the memEnd token.
module store_rr_scheduler #(
    parameter int unsigned NUM_CONTROLS = 1,
    parameter int unsigned NUM_STORES   = 2,
    parameter int unsigned DATA_TYPE    = 32,
    parameter int unsigned ADDR_TYPE    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           memStart_valid,
    output logic                           memStart_ready,
    output logic                           memEnd_valid,
    input  logic                           memEnd_ready,
    input  logic                           ctrlEnd_valid,
    output logic                           ctrlEnd_ready,
    input  logic [NUM_CONTROLS*32-1:0]     ctrl,
    input  logic [NUM_CONTROLS-1:0]        ctrl_valid,
    output logic [NUM_CONTROLS-1:0]        ctrl_ready,
    input  logic [NUM_STORES*ADDR_TYPE-1:0] stAddr,
    input  logic [NUM_STORES-1:0]          stAddr_valid,
    output logic [NUM_STORES-1:0]          stAddr_ready,
    input  logic [NUM_STORES*DATA_TYPE-1:0] stData,
    input  logic [NUM_STORES-1:0]          stData_valid,
    output logic [NUM_STORES-1:0]          stData_ready,
    output logic                           storeEn,
    output logic [ADDR_TYPE-1:0]           storeAddr,
    output logic [DATA_TYPE-1:0]           storeData
);

    localparam int unsigned PTR_W = (NUM_STORES > 1) ? $clog2(NUM_STORES) : 1;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 store_en_q, store_en_d;
    logic [ADDR_TYPE-1:0] store_addr_q, store_addr_d;
    logic [DATA_TYPE-1:0] store_data_q, store_data_d;

    logic                  active;
    logic                  grant_any;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_STORES-1:0] grant;
    logic [CNT_W-1:0]      ctrl_sum;

    assign active = (state_q == RUN) || (state_q == DRAIN);

    // First eligible port scanning upward from the pointer, wrapping around.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] sel;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < NUM_STORES; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_STORES) idx = idx - NUM_STORES;
            sel = PTR_W'(idx);
            if (!grant_any && active && stAddr_valid[sel] && stData_valid[sel]) begin
                grant_any  = 1'b1;
                grant_idx  = sel;
                grant[sel] = 1'b1;
            end
        end
    end

    always_comb begin
        ctrl_sum = '0;
        for (int unsigned i = 0; i < NUM_CONTROLS; i++) begin
            if (ctrl_valid[i] && active) ctrl_sum = ctrl_sum + ctrl[i*32 +: 32];
        end
    end

    // Next-state, pointer, counter and write-stage logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q + ctrl_sum - CNT_W'(grant_any);
        store_en_d   = grant_any;
        store_addr_d = store_addr_q;
        store_data_d = store_data_q;

        if (grant_any) begin
            store_addr_d = stAddr[grant_idx*ADDR_TYPE +: ADDR_TYPE];
            store_data_d = stData[grant_idx*DATA_TYPE +: DATA_TYPE];
            ptr_d = (32'(grant_idx) + 1 >= NUM_STORES) ? '0 : grant_idx + PTR_W'(1);
        end

        unique case (state_q)
            IDLE:  if (memStart_valid) state_d = RUN;
            RUN:   if (ctrlEnd_valid)  state_d = DRAIN;
            DRAIN: if (cnt_q == '0 && ctrl_valid == '0 && !grant_any && !store_en_q)
                       state_d = DONE;
            DONE:  if (memEnd_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            store_en_q   <= 1'b0;
            store_addr_q <= '0;
            store_data_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            store_en_q   <= store_en_d;
            store_addr_q <= store_addr_d;
            store_data_q <= store_data_d;
        end
    end

    assign memStart_ready = (state_q == IDLE);
    assign ctrlEnd_ready  = (state_q == RUN);
    assign memEnd_valid   = (state_q == DONE);
    assign ctrl_ready     = {NUM_CONTROLS{active}};
    assign stAddr_ready   = grant;
    assign stData_ready   = grant;
    assign storeEn        = store_en_q;
    assign storeAddr      = store_addr_q;
    assign storeData      = store_data_q;

endmodule

// File: doc/store_rr_scheduler.md
Name: store_rr_scheduler

Overview:
Store-only memory scheduler placed between NUM_STORES elastic store ports and the single write port of a dual-port BRAM. It shares the write port round-robin, registers the winning write, and counts pending stores from control tokens. A start/end FSM returns the memEnd token only after all announced stores have committed.

Parameters:
NUM_CONTROLS, 1, number of control (store-count) input channels, 32 bits each
NUM_STORES, 2, number of store ports arbitrated; must be at least 1
DATA_TYPE, 32, store data width
ADDR_TYPE, 32, store address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
memStart_valid  in  1  start token valid
memStart_ready  out  1  start token ready
memEnd_valid  out  1  end token valid
memEnd_ready  in  1  end token ready
ctrlEnd_valid  in  1  "no more control tokens" valid
ctrlEnd_ready  out  1  ctrlEnd ready
ctrl  in  NUM_CONTROLS*32  per-channel store counts (unsigned)
ctrl_valid  in  NUM_CONTROLS  ctrl valids
ctrl_ready  out  NUM_CONTROLS  ctrl readies
stAddr  in  NUM_STORES*ADDR_TYPE  store addresses, port i at slice [i*ADDR_TYPE +: ADDR_TYPE]
stAddr_valid  in  NUM_STORES  address valids
stAddr_ready  out  NUM_STORES  address readies
stData  in  NUM_STORES*DATA_TYPE  store data, port i at slice [i*DATA_TYPE +: DATA_TYPE]
stData_valid  in  NUM_STORES  data valids
stData_ready  out  NUM_STORES  data readies
storeEn  out  1  BRAM write enable (registered)
storeAddr  out  ADDR_TYPE  BRAM write address (registered)
storeData  out  DATA_TYPE  BRAM write data (registered)

Behaviour:
- Clocking/reset: single clock clk, reset rst synchronous active-high. Reset: state=IDLE, rr pointer=0, counter=0, storeEn=0, storeAddr=0, storeData=0. Combinational readies and memEnd_valid evaluate low in IDLE except memStart_ready=1.
- Reset mid-operation: in-flight write is dropped, counter cleared, return to IDLE.
- FSM:
  - IDLE: memStart_ready=1; go to RUN on memStart_valid.
  - RUN: ctrlEnd_ready=1; go to DRAIN on ctrlEnd_valid.
  - DRAIN: go to DONE when counter==0, ctrl_valid all zero, no store accepted this cycle, and storeEn==0.
  - DONE: memEnd_valid=1; go to IDLE on memEnd_ready.
- Eligibility: port i is eligible when stAddr_valid[i] && stData_valid[i] and state is RUN or DRAIN.
- Arbitration: grant the first eligible port scanning ptr, ptr+1, ... (mod NUM_STORES). At most one grant per cycle.
- Acceptance: stAddr_ready[i] = stData_ready[i] = grant[i], combinational. A port never sees ready on only one of its two channels.
- Pointer update: on a grant to port g, ptr <= (g+1) mod NUM_STORES. With no grant, ptr is held.
- Write register: the grant cycle loads storeAddr/storeData from port g and sets storeEn=1 in the next cycle. Latency is one cycle. storeEn=0 in cycles following no grant; addr/data hold their last value.
- ctrl_ready: all ones in RUN and DRAIN, zero otherwise.
- Counter (32-bit two's complement, wraps mod 2^32): each cycle add the sum of ctrl[i] over channels with ctrl_valid[i] && ctrl_ready[i], then subtract 1 if a store is granted this cycle.
  - Same-cycle ctrl tokens and a store grant are both applied.
  - Counter may go transiently negative when stores precede their ctrl token. This is legal; only ==0 is tested.
- No backpressure from BRAM: the write port accepts every cycle, so throughput is one store per cycle.
- NUM_STORES=1: pointer stays 0.

Test Plan:
- Reset: assert rst 2 cycles with all valids high -> all readies 0 except memStart_ready=1, storeEn=0, memEnd_valid=0.
- Basic: start; ctrl[0]=3 with valid 1 cycle; port0 issues addr 0x10/0x11/0x12, data 0xA/0xB/0xC; then ctrlEnd -> three storeEn pulses each 1 cycle after acceptance with matching addr/data; memEnd_valid rises only after the third write.
- Round-robin: NUM_STORES=2, both ports continuously valid for 4 cycles -> grants alternate 0,1,0,1; storeAddr follows the same order.
- Early stores: port1 stores twice before ctrl=2 arrives, ctrlEnd asserted between them -> counter reaches -2 then 0; memEnd_valid only after ctrl is consumed and storeEn drops.
- Simultaneous: same cycle ctrl=1 and store grant with counter=0 -> counter stays 0, no premature DONE while ctrl_valid is high that cycle.
- Mid-operation reset: rst during DRAIN with counter=5 -> next cycle state IDLE, counter 0, storeEn 0; a fresh start/ctrl=0/ctrlEnd sequence yields memEnd_valid within 2 cycles of ctrlEnd.
